serial_stuff_tx: RTL and testbench

- Serial transmitter for the run-length-framed bit stream consumed by the team's consecutive-ones serial detector.
- Accepts parallel words over a valid/ready handshake and shifts them out MSB first, one bit per clk.
- After MAX_RUN consecutive 1s it inserts a 0, so data never trips the detector.
- On request, emits an unstuffed flag of MAX_RUN+1 ones that the detector recognises as a frame delimiter.

---
 rtl/serial_stuff_tx.sv | 144 ++++++++++++++
 tb/tb_serial_stuff_tx.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_stuff_tx.sv
// serial_stuff_tx
// Shifts parallel words out MSB first, inserting a 0 after every MAX_RUN
// consecutive 1s so data never looks like a frame delimiter. On request it
// sends an unstuffed flag of MAX_RUN+1 ones instead.
module serial_stuff_tx #(
  parameter int unsigned WIDTH   = 17,
  parameter int unsigned MAX_RUN = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             flag_req,
  output logic             din_ready,
  output logic             ostream,
  output logic             ovalid,
  output logic             frame_done
);

  localparam int unsigned IDX_W = $clog2(WIDTH);
  localparam int unsigned RUN_W = $clog2(MAX_RUN + 2);

  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_RUN);
  localparam logic [RUN_W-1:0] RUN_SAT = RUN_W'(MAX_RUN + 1);
  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_STUFF,
    S_FLAG
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;     // remaining data bits, next one at MSB
  logic [IDX_W-1:0] r_idx;       // data bits still to emit
  logic [RUN_W-1:0] r_run;       // consecutive 1s on the line (or flag ones sent)
  logic             r_ostream;
  logic             r_ovalid;
  logic             r_frame_done;

  logic             w_bit;
  logic [RUN_W-1:0] w_run_inc;
  logic [RUN_W-1:0] w_run_next;
  logic             w_last;

  // Next data bit and the run count it would produce
  always_comb begin
    w_bit      = r_shift[WIDTH-1];
    w_run_inc  = (r_run == RUN_SAT) ? r_run : r_run + RUN_ONE;
    w_run_next = w_bit ? w_run_inc : '0;
    w_last     = (r_idx == IDX_ONE);
  end

  // Ready only while idle and out of reset
  always_comb begin
    din_ready = (r_state == S_IDLE) && rst_n;
  end

  assign ostream    = r_ostream;
  assign ovalid     = r_ovalid;
  assign frame_done = r_frame_done;

  // Framing FSM with registered line outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_shift      <= '0;
      r_idx        <= '0;
      r_run        <= '0;
      r_ostream    <= 1'b0;
      r_ovalid     <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ostream    <= 1'b0;
          r_ovalid     <= 1'b0;
          r_frame_done <= 1'b0;
          r_run        <= '0;
          if (flag_req) begin
            // flag wins over data; din stays held by the source
            r_ostream <= 1'b1;
            r_ovalid  <= 1'b1;
            r_run     <= RUN_ONE;
            r_state   <= S_FLAG;
          end else if (din_valid) begin
            r_shift   <= {din[WIDTH-2:0], 1'b0};
            r_ostream <= din[WIDTH-1];
            r_ovalid  <= 1'b1;
            r_idx     <= IDX_TOP;
            r_run     <= din[WIDTH-1] ? RUN_ONE : '0;
            r_state   <= S_DATA;
          end
        end

        S_DATA, S_STUFF: begin
          if (r_frame_done) begin
            r_ostream    <= 1'b0;
            r_ovalid     <= 1'b0;
            r_frame_done <= 1'b0;
            r_run        <= '0;
            r_state      <= S_IDLE;
          end else if (r_run == RUN_MAX) begin
            // stuffed 0; it closes the frame when no data bits remain
            r_ostream    <= 1'b0;
            r_run        <= '0;
            r_frame_done <= (r_idx == '0);
            r_state      <= S_STUFF;
          end else begin
            // the last data bit ends the frame unless it completes a run
            r_ostream    <= w_bit;
            r_shift      <= {r_shift[WIDTH-2:0], 1'b0};
            r_idx        <= (r_idx != '0) ? r_idx - IDX_ONE : r_idx;
            r_run        <= w_run_next;
            r_frame_done <= w_last && (w_run_next != RUN_MAX);
            r_state      <= S_DATA;
          end
        end

        S_FLAG: begin
          if (r_frame_done) begin
            r_ostream    <= 1'b0;
            r_ovalid     <= 1'b0;
            r_frame_done <= 1'b0;
            r_run        <= '0;
            r_state      <= S_IDLE;
          end else begin
            r_ostream    <= 1'b1;
            r_run        <= w_run_inc;
            r_frame_done <= (w_run_inc == RUN_SAT);
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_stuff_tx.sv
// Scoreboard bench for serial_stuff_tx: expected line bits are queued when a
// word or flag is offered and compared as the DUT emits valid bits.
module tb_serial_stuff_tx;

  localparam int unsigned WIDTH   = 17;
  localparam int unsigned MAX_RUN = 3;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             flag_req;
  logic             din_ready;
  logic             ostream;
  logic             ovalid;
  logic             frame_done;

  typedef struct packed {
    logic b;
    logic fd;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests;
  int   n_fail;
  int   n_seen;
  bit   mon_prev_fd;

  serial_stuff_tx #(
    .WIDTH  (WIDTH),
    .MAX_RUN(MAX_RUN)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_valid (din_valid),
    .flag_req  (flag_req),
    .din_ready (din_ready),
    .ostream   (ostream),
    .ovalid    (ovalid),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference framing: MSB first, a 0 after every MAX_RUN ones, done on last bit
  task automatic push_model(input logic [WIDTH-1:0] w);
    bit bq[$];
    int unsigned run;
    run = 0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      bq.push_back(w[i]);
      if (w[i]) run++;
      else run = 0;
      if (run == MAX_RUN) begin
        bq.push_back(1'b0);
        run = 0;
      end
    end
    foreach (bq[k]) exp_q.push_back('{b: bq[k], fd: (k == bq.size() - 1)});
  endtask

  task automatic push_lit(input logic [31:0] bits, input int unsigned len);
    for (int i = int'(len) - 1; i >= 0; i--)
      exp_q.push_back('{b: bits[i], fd: (i == 0)});
  endtask

  task automatic push_flag();
    for (int unsigned i = 0; i <= MAX_RUN; i++)
      exp_q.push_back('{b: 1'b1, fd: (i == MAX_RUN)});
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int unsigned n;
    n = 0;
    while (!din_ready && n < 200) begin
      step();
      n++;
    end
    if (!din_ready) check("ready_timeout", 32'd1, 32'd0);
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w);
    wait_ready();
    din       = w;
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int unsigned n;
    n = 0;
    while (!(exp_q.size() == 0 && din_ready) && n < 200) begin
      step();
      n++;
    end
    check("frame_timeout", (exp_q.size() == 0 && din_ready) ? 32'd1 : 32'd0, 32'd1);
  endtask

  // Monitor: compare each valid bit against the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_prev_fd = 1'b0;
      end else begin
        if (mon_prev_fd) begin
          check("gap_ready", {31'd0, din_ready}, 32'd1);
          check("gap_ovalid", {31'd0, ovalid}, 32'd0);
          check("gap_ostream", {31'd0, ostream}, 32'd0);
        end
        if (ovalid) begin
          n_seen++;
          check("busy_ready", {31'd0, din_ready}, 32'd0);
          if (exp_q.size() == 0) begin
            check("extra_bit", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("ostream", {31'd0, ostream}, {31'd0, e.b});
            check("frame_done", {31'd0, frame_done}, {31'd0, e.fd});
          end
          mon_prev_fd = frame_done;
        end else begin
          check("idle_fd", {31'd0, frame_done}, 32'd0);
          mon_prev_fd = 1'b0;
        end
      end
    end
  end

  initial begin
    int unsigned n;
    int          base;
    n_tests     = 0;
    n_fail      = 0;
    n_seen      = 0;
    mon_prev_fd = 1'b0;
    rst_n       = 1'b0;
    din         = '0;
    din_valid   = 1'b0;
    flag_req    = 1'b0;

    #12;
    check("rst_ostream", {31'd0, ostream}, 32'd0);
    check("rst_ovalid", {31'd0, ovalid}, 32'd0);
    check("rst_fd", {31'd0, frame_done}, 32'd0);
    check("rst_ready", {31'd0, din_ready}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check("ready_after_rst", {31'd0, din_ready}, 32'd1);

    // Mixed word: 20 line bits with three stuffs
    push_lit(32'b11011101110010111010, 20);
    send_word(17'b11011111101011110);
    wait_idle();

    // All ones, trailing one, trailing stuff, all zeros
    push_model(17'h1FFFF);
    send_word(17'h1FFFF);
    wait_idle();
    push_model(17'h00007);
    send_word(17'h00007);
    wait_idle();
    push_model(17'h00000);
    send_word(17'h00000);
    wait_idle();

    // Flag and word requested together: flag first, one idle 0, then word
    wait_ready();
    push_flag();
    push_model(17'h1FFFF);
    din       = 17'h1FFFF;
    din_valid = 1'b1;
    flag_req  = 1'b1;
    step();
    flag_req = 1'b0;
    n = 0;
    while (!frame_done && n < 50) begin
      step();
      n++;
    end
    check("flag_fd_seen", {31'd0, frame_done}, 32'd1);
    step();
    check("flag_gap_ready", {31'd0, din_ready}, 32'd1);
    step();
    check("word_after_flag", {31'd0, ovalid}, 32'd1);
    din_valid = 1'b0;
    wait_idle();

    // Asynchronous reset in the middle of a word
    push_model(17'h1FFFF);
    base = n_seen;
    send_word(17'h1FFFF);
    n = 0;
    while (n_seen < base + 8 && n < 50) begin
      step();
      n++;
    end
    check("reached_bit8", n_seen - base, 32'd8);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("mid_rst_ostream", {31'd0, ostream}, 32'd0);
    check("mid_rst_ovalid", {31'd0, ovalid}, 32'd0);
    check("mid_rst_fd", {31'd0, frame_done}, 32'd0);
    check("mid_rst_ready", {31'd0, din_ready}, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", {31'd0, din_ready}, 32'd1);
    push_model(17'h1FFFF);
    send_word(17'h1FFFF);
    wait_idle();

    // A few random words
    for (int i = 0; i < 6; i++) begin
      logic [WIDTH-1:0] w;
      w = WIDTH'($urandom);
      push_model(w);
      send_word(w);
      wait_idle();
    end

    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
